// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush/freeze controller: memory-wait FSM, branch flush slots, memory timeout.
// Optional perf counters (STALL_CNT, FLUSH_CNT, MEMWAIT_CNT) enabled by `define STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
  parameter int FLUSH_SLOTS = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic CLK,
  input  logic RST,
  input  logic HAZARD_DETECTED,
  input  logic BRANCH_TAKEN,
  input  logic MEM_REQ,
  input  logic MEM_READY,
  output logic PC_WRITE_EN,
  output logic IF_ID_WRITE_EN,
  output logic IF_ID_FLUSH,
  output logic ID_EXE_BUBBLE,
  output logic PIPE_FREEZE,
  output logic MEM_ERR
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] STALL_CNT,
  output logic [CNT_WIDTH-1:0] FLUSH_CNT,
  output logic [CNT_WIDTH-1:0] MEMWAIT_CNT
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam logic [3:0]  FLUSH_INIT   = 4'(FLUSH_SLOTS - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  state_t      eff_state;
  logic [3:0]  flush_left_q, flush_left_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_err_d;
  logic        mem_stall;
  logic        timeout;

  assign mem_stall = MEM_REQ & ~MEM_READY;
  assign timeout   = (state_q == MEM_WAIT) && mem_stall && (wait_cnt_q >= TIMEOUT_LAST);
  // While waiting on memory, behave as the state the wait interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d        = state_q;
    ret_d          = ret_q;
    flush_left_d   = flush_left_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = MEM_ERR;
    PC_WRITE_EN    = 1'b1;
    IF_ID_WRITE_EN = 1'b1;
    IF_ID_FLUSH    = 1'b0;
    ID_EXE_BUBBLE  = 1'b0;
    PIPE_FREEZE    = 1'b0;

    if (mem_stall && !timeout) begin
      PC_WRITE_EN    = 1'b0;
      IF_ID_WRITE_EN = 1'b0;
      PIPE_FREEZE    = 1'b1;
      state_d        = MEM_WAIT;
      ret_d          = eff_state;
      wait_cnt_d     = wait_cnt_q + 16'd1;
    end else begin
      // A timeout releases the freeze exactly like a ready cycle, but flags the error.
      wait_cnt_d = 16'd0;
      state_d    = eff_state;
      if (timeout) mem_err_d = 1'b1;
      if (eff_state == FLUSH) begin
        IF_ID_FLUSH  = 1'b1;
        flush_left_d = (flush_left_q <= 4'd1) ? 4'd0 : flush_left_q - 4'd1;
        if (flush_left_q <= 4'd1) state_d = RUN;
      end else if (HAZARD_DETECTED) begin
        PC_WRITE_EN    = 1'b0;
        IF_ID_WRITE_EN = 1'b0;
        ID_EXE_BUBBLE  = 1'b1;
      end else if (BRANCH_TAKEN) begin
        IF_ID_FLUSH = 1'b1;
        if (FLUSH_SLOTS > 1) begin
          flush_left_d = FLUSH_INIT;
          state_d      = FLUSH;
        end
      end
    end

    if (RST) begin
      PC_WRITE_EN    = 1'b0;
      IF_ID_WRITE_EN = 1'b0;
      IF_ID_FLUSH    = 1'b1;
      ID_EXE_BUBBLE  = 1'b1;
      PIPE_FREEZE    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      ret_q        <= RUN;
      flush_left_q <= 4'd0;
      wait_cnt_q   <= 16'd0;
      MEM_ERR      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      flush_left_q <= flush_left_d;
      wait_cnt_q   <= wait_cnt_d;
      MEM_ERR      <= mem_err_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      STALL_CNT   <= '0;
      FLUSH_CNT   <= '0;
      MEMWAIT_CNT <= '0;
    end else begin
      STALL_CNT   <= sat_inc(STALL_CNT, ID_EXE_BUBBLE);
      FLUSH_CNT   <= sat_inc(FLUSH_CNT, IF_ID_FLUSH);
      MEMWAIT_CNT <= sat_inc(MEMWAIT_CNT, PIPE_FREEZE);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: per-cycle behavioural model plus directed literal checks.
`timescale 1ns/1ps
module tb_pipeline_stall_controller;

  localparam int FLUSH_SLOTS = 3;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_WIDTH   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic haz = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic pc_we, ifid_we, ifid_flush, bubble, freeze, mem_err;
`ifdef STALL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .FLUSH_SLOTS(FLUSH_SLOTS),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .HAZARD_DETECTED(haz),
    .BRANCH_TAKEN   (br),
    .MEM_REQ        (req),
    .MEM_READY      (rdy),
    .PC_WRITE_EN    (pc_we),
    .IF_ID_WRITE_EN (ifid_we),
    .IF_ID_FLUSH    (ifid_flush),
    .ID_EXE_BUBBLE  (bubble),
    .PIPE_FREEZE    (freeze),
    .MEM_ERR        (mem_err)
`ifdef STALL_PERF_CNT_EN
    ,
    .STALL_CNT      (stall_cnt),
    .FLUSH_CNT      (flush_cnt),
    .MEMWAIT_CNT    (memwait_cnt)
`endif
  );

  // Output vector order: {pc_we, ifid_we, flush, bubble, freeze, mem_err}
  logic [5:0] dut_o;
  assign dut_o = {pc_we, ifid_we, ifid_flush, bubble, freeze, mem_err};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flush slots still owed, consecutive stalled cycles, sticky error, event tallies.
  int m_pending = 0;
  int m_waited  = 0;
  int m_err     = 0;
  int m_stalls  = 0;
  int m_flushes = 0;
  int m_freezes = 0;

  always @(negedge clk) begin : model
    logic [5:0] e;
    logic stalled, tmo;
`ifdef STALL_PERF_CNT_EN
    chk("stall_cnt",   stall_cnt,   m_stalls);
    chk("flush_cnt",   flush_cnt,   m_flushes);
    chk("memwait_cnt", memwait_cnt, m_freezes);
`endif
    if (rst) begin
      e = {5'b00110, m_err[0]};
      chk("model_out", 32'(dut_o), 32'(e));
      m_pending = 0; m_waited = 0; m_err = 0;
      m_stalls = 0; m_flushes = 0; m_freezes = 0;
    end else begin
      stalled = req & ~rdy;
      tmo     = stalled && (m_waited == MEM_TIMEOUT - 1);
      e       = {5'b11000, m_err[0]};
      if (stalled && !tmo) begin
        e[5] = 1'b0; e[4] = 1'b0; e[1] = 1'b1;
        m_waited++;
      end else begin
        m_waited = 0;
        if (m_pending > 0) begin
          e[3] = 1'b1;
          m_pending--;
        end else if (haz) begin
          e[5] = 1'b0; e[4] = 1'b0; e[2] = 1'b1;
        end else if (br) begin
          e[3] = 1'b1;
          m_pending = FLUSH_SLOTS - 1;
        end
      end
      chk("model_out", 32'(dut_o), 32'(e));
      if (tmo) m_err = 1;
      if (e[2]) m_stalls++;
      if (e[3]) m_flushes++;
      if (e[1]) m_freezes++;
    end
  end

  // Apply one cycle of inputs, returning just after the following negedge.
  task automatic apply(input logic r, input logic h, input logic b, input logic q, input logic y);
    @(posedge clk); #1;
    rst = r; haz = h; br = b; req = q; rdy = y;
    @(negedge clk); #1;
  endtask

  task automatic lit(input string name, input logic [5:0] exp);
    chk(name, 32'(dut_o), 32'(exp));
  endtask

`ifdef STALL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] mw_base;
`endif

  initial begin
    @(negedge clk); #1;
    lit("reset_c0", 6'b001100);
    apply(1, 0, 0, 0, 0); lit("reset_c1", 6'b001100);
    apply(0, 0, 0, 0, 0); lit("idle_after_reset", 6'b110000);

    // Hazard wins over branch
    apply(0, 1, 1, 0, 0); lit("hazard_c1", 6'b000100);
    apply(0, 1, 1, 0, 0); lit("hazard_c2", 6'b000100);
    apply(0, 0, 0, 0, 0); lit("hazard_done", 6'b110000);

    // Branch pulse -> three flush cycles, hazards in the shadow ignored
    apply(0, 0, 1, 0, 0); lit("br_flush_c1", 6'b111000);
    apply(0, 1, 0, 0, 0); lit("br_flush_c2", 6'b111000);
    apply(0, 1, 0, 0, 0); lit("br_flush_c3", 6'b111000);
    apply(0, 0, 0, 0, 0); lit("br_flush_done", 6'b110000);

    // Four-cycle memory wait
`ifdef STALL_PERF_CNT_EN
    mw_base = memwait_cnt;
`endif
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 1, 0); lit("mem_freeze", 6'b000010);
    end
    apply(0, 0, 0, 1, 1); lit("mem_ready", 6'b110000);
    apply(0, 0, 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
    chk("memwait_delta", memwait_cnt - mw_base, 4);
`endif

    // Memory wait outranks hazard; hazard honoured on the ready cycle
    apply(0, 1, 0, 1, 0); lit("prio_mem_over_haz", 6'b000010);
    apply(0, 1, 0, 1, 1); lit("haz_on_ready", 6'b000100);
    apply(0, 0, 0, 0, 0); lit("prio_done", 6'b110000);

    // Stall arriving mid-flush pauses the flush
    apply(0, 0, 1, 0, 0); lit("fs_c1", 6'b111000);
    apply(0, 0, 0, 1, 0); lit("fs_freeze1", 6'b000010);
    apply(0, 0, 0, 1, 0); lit("fs_freeze2", 6'b000010);
    apply(0, 0, 0, 1, 1); lit("fs_resume1", 6'b111000);
    apply(0, 0, 0, 0, 0); lit("fs_resume2", 6'b111000);
    apply(0, 0, 0, 0, 0); lit("fs_done", 6'b110000);

    // Timeout: 7 frozen cycles, release on the 8th, error sticky afterwards
    for (int i = 0; i < 7; i++) begin
      apply(0, 0, 0, 1, 0); lit("to_freeze", 6'b000010);
    end
    apply(0, 0, 0, 1, 0); lit("to_release", 6'b110000);
    apply(0, 0, 0, 1, 0); lit("to_refreeze_err", 6'b000011);
    apply(0, 0, 0, 0, 0); lit("err_sticky1", 6'b110001);
    apply(0, 0, 1, 0, 0); lit("err_sticky_br", 6'b111001);
    apply(0, 0, 0, 0, 0); lit("err_sticky_fl", 6'b111001);

    // Reset mid-flush aborts it and clears the error
    apply(1, 0, 0, 0, 0); lit("rst2_c0", 6'b001101);
    apply(1, 0, 0, 0, 0); lit("rst2_c1", 6'b001100);
    apply(0, 0, 0, 0, 0); lit("rst2_release", 6'b110000);
    apply(0, 0, 0, 0, 0); lit("rst2_idle", 6'b110000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
